// File: rtl/cma_fir_engine.sv
// Adaptive FIR equalizer core: serial MAC, CMA error, per-tap update walk.
// Sample in via valid/ready; tap updates go out to an external cma_base.
module cma_fir_engine #(
    parameter int NTAPS = 7,
    parameter int NB_I  = 18,
    parameter int NBF_I = 15,
    parameter int NB    = 8,
    parameter int NBF   = 7
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [NB_I-1:0]          i_x,
    output logic                     o_ready,
    input  logic                     i_adapt_en,
    input  logic [NB_I-1:0]          i_r2,
    output logic [NB_I-1:0]          o_y,
    output logic                     o_y_valid,
    output logic [NB-1:0]            o_error,
    output logic                     o_upd_valid,
    output logic [$clog2(NTAPS)-1:0] o_tap_idx,
    output logic [NB_I-1:0]          o_xk,
    output logic [NB_I-1:0]          o_fir_out,
    output logic [NB-1:0]            o_w,
    input  logic [NB-1:0]            i_w_new
);

    localparam int CT  = NTAPS / 2;
    localparam int IW  = $clog2(NTAPS);
    localparam int PW  = NB_I + NB;
    localparam int AW  = PW + IW;
    localparam int YTW = AW - NBF;
    localparam int SW  = 2 * NB_I;
    localparam int QW  = SW - NBF_I;
    localparam int DW  = QW + 1;
    localparam int EW  = NB_I + DW;
    localparam int ESH = 2 * NBF_I - NBF;
    localparam int ETW = EW - ESH;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ERR, S_UPD} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   cnt;
    logic [NB_I-1:0] x_q [NTAPS];
    logic [NB-1:0]   w_q [NTAPS];
    logic [AW-1:0]   acc;

    logic            accept, last;
    logic [NB_I-1:0] xk_sel;
    logic [NB-1:0]   wk_sel;
    logic [PW-1:0]   prod;
    logic [YTW-1:0]  y_top;
    logic            y_ovf;
    logic [NB_I-1:0] y_cur;
    logic [SW-1:0]   sq;
    logic [QW-1:0]   p;
    logic [DW-1:0]   d;
    logic [EW-1:0]   ef;
    logic [ETW-1:0]  e_top;
    logic            e_ovf;
    logic [NB-1:0]   e_cur;
    logic            unused_lsbs;

    assign o_ready = (state == S_IDLE);
    assign accept  = i_valid & o_ready;
    assign last    = (cnt == IW'(NTAPS - 1));
    assign xk_sel  = x_q[cnt];
    assign wk_sel  = w_q[cnt];

    assign prod = {{NB{xk_sel[NB_I-1]}}, xk_sel}
                * {{NB_I{wk_sel[NB-1]}}, wk_sel};

    // Drop NBF fraction bits, then clamp to the NB_I signed range.
    assign y_top = acc[AW-1:NBF];
    assign y_ovf = !((&y_top[YTW-1:NB_I-1]) || !(|y_top[YTW-1:NB_I-1]));
    assign y_cur = y_ovf ? {y_top[YTW-1], {(NB_I-1){~y_top[YTW-1]}}}
                         : y_top[NB_I-1:0];

    assign sq = {{NB_I{y_cur[NB_I-1]}}, y_cur}
              * {{NB_I{y_cur[NB_I-1]}}, y_cur};
    assign p  = sq[SW-1:NBF_I];
    assign d  = {p[QW-1], p}
              - {{(DW-NB_I){i_r2[NB_I-1]}}, i_r2};
    assign ef = {{DW{y_cur[NB_I-1]}}, y_cur}
              * {{NB_I{d[DW-1]}}, d};

    assign e_top = ef[EW-1:ESH];
    assign e_ovf = !((&e_top[ETW-1:NB-1]) || !(|e_top[ETW-1:NB-1]));
    assign e_cur = e_ovf ? {e_top[ETW-1], {(NB-1){~e_top[ETW-1]}}}
                         : e_top[NB-1:0];

    assign unused_lsbs = ^{acc[NBF-1:0], sq[NBF_I-1:0], ef[ESH-1:0]};

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (accept) state_nx = S_MAC;
            S_MAC:   if (last) state_nx = S_ERR;
            S_ERR:   state_nx = i_adapt_en ? S_UPD : S_IDLE;
            S_UPD:   if (last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                cnt <= '0;
            else if (state == S_MAC || state == S_UPD)
                cnt <= cnt + IW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= '0;
                w_q[k] <= (k == CT) ? {1'b0, {(NB-1){1'b1}}} : '0;
            end
            acc       <= '0;
            o_y       <= '0;
            o_error   <= '0;
            o_y_valid <= 1'b0;
        end else begin
            o_y_valid <= (state == S_ERR);
            if (accept) begin
                for (int k = NTAPS - 1; k > 0; k--)
                    x_q[k] <= x_q[k-1];
                x_q[0] <= i_x;
                acc    <= '0;
            end
            if (state == S_MAC)
                acc <= acc + {{IW{prod[PW-1]}}, prod};
            if (state == S_ERR) begin
                o_y     <= y_cur;
                o_error <= e_cur;
            end
            if (state == S_UPD)
                w_q[cnt] <= i_w_new;
        end
    end

    always_comb begin
        o_upd_valid = 1'b0;
        o_tap_idx   = '0;
        o_xk        = '0;
        o_w         = '0;
        if (state == S_UPD) begin
            o_upd_valid = 1'b1;
            o_tap_idx   = cnt;
            o_xk        = xk_sel;
            o_w         = wk_sel;
        end
    end

    assign o_fir_out = o_y;

endmodule

// File: tb/tb_cma_fir_engine.sv
// Directed bench for cma_fir_engine with a combinational updater stub.
// Expected values are hand-computed fixed-point results.
module tb_cma_fir_engine;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, i_adapt_en;
    logic [17:0] i_x, i_r2;
    logic        o_ready, o_y_valid, o_upd_valid;
    logic [17:0] o_y, o_xk, o_fir_out;
    logic [7:0]  o_error, o_w, w_new;
    logic [2:0]  o_tap_idx;

    logic [1:0]  stub_mode;
    logic [7:0]  stub_val;

    int n_assert = 0;
    int n_fail   = 0;

    int          ylat, rlat, nb;
    logic [17:0] cap_y;
    logic [7:0]  cap_e;
    logic [2:0]  bi [8];
    logic [7:0]  bw [8];
    logic [17:0] bx [8];
    logic [17:0] bf [8];
    logic [17:0] ys [8];
    int          nacc, ny, bad_int;

    always #5 clk = ~clk;

    // 0: w+1, 1: constant, 2: constant on center tap only, 3: hold
    assign w_new = (stub_mode == 2'd0) ? o_w + 8'd1 :
                   (stub_mode == 2'd1) ? stub_val :
                   (stub_mode == 2'd2) ? ((o_tap_idx == 3'd3) ? stub_val : 8'd0) :
                   o_w;

    cma_fir_engine dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_x         (i_x),
        .o_ready     (o_ready),
        .i_adapt_en  (i_adapt_en),
        .i_r2        (i_r2),
        .o_y         (o_y),
        .o_y_valid   (o_y_valid),
        .o_error     (o_error),
        .o_upd_valid (o_upd_valid),
        .o_tap_idx   (o_tap_idx),
        .o_xk        (o_xk),
        .o_fir_out   (o_fir_out),
        .o_w         (o_w),
        .i_w_new     (w_new)
    );

    task automatic chk(input string tag, input logic [39:0] obs,
                       input logic [39:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        i_rst   = 1'b1;
        i_valid = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    // One sample through the core; cycle n counts from the accept edge.
    task automatic run_op(input logic [17:0] x, input logic adapt);
        int n;
        @(negedge clk);
        chk("ready_before_op", o_ready, 1);
        i_x        = x;
        i_valid    = 1'b1;
        i_adapt_en = adapt;
        @(negedge clk);
        i_valid = 1'b0;
        n = 1; nb = 0; ylat = 0; rlat = 0;
        while (1) begin
            if (o_y_valid && ylat == 0) begin
                ylat  = n;
                cap_y = o_y;
                cap_e = o_error;
            end
            if (o_upd_valid) begin
                if (nb < 8) begin
                    bi[nb] = o_tap_idx;
                    bw[nb] = o_w;
                    bx[nb] = o_xk;
                    bf[nb] = o_fir_out;
                end
                nb++;
            end
            if (o_ready) begin
                rlat = n;
                break;
            end
            if (n >= 40) break;
            @(negedge clk);
            n++;
        end
        chk("op_timeout", (rlat != 0), 1);
    endtask

    // i_valid held high; each ready cycle is one accept.
    task automatic stream(input int period, input int ny_target);
        int cyc, lastc;
        cyc = 0; lastc = -1; nacc = 0; ny = 0; bad_int = 0;
        while (ny < ny_target && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (o_y_valid) begin
                if (ny < 8) ys[ny] = o_y;
                ny++;
            end
            if (o_ready) begin
                if (lastc >= 0 && cyc - lastc != period) bad_int++;
                lastc = cyc;
                nacc++;
                i_x = 18'(nacc * 256);
            end
            i_valid = 1'b1;
        end
        i_valid = 1'b0;
        chk("stream_timeout", (ny >= ny_target), 1);
    endtask

    initial begin
        logic [7:0]  ew [7];
        logic [17:0] ex [7];
        int found;
        logic seen;

        i_rst = 1'b1; i_valid = 1'b0; i_adapt_en = 1'b0;
        i_x = '0; i_r2 = 18'h04000;
        stub_mode = 2'd3; stub_val = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;

        chk("rst_ready",     o_ready, 1);
        chk("rst_y",         o_y, 0);
        chk("rst_err",       o_error, 0);
        chk("rst_y_valid",   o_y_valid, 0);
        chk("rst_upd_valid", o_upd_valid, 0);
        chk("rst_tap_idx",   o_tap_idx, 0);
        chk("rst_xk",        o_xk, 0);
        chk("rst_w",         o_w, 0);

        // Test 1: impulse reaches center tap on the 4th sample
        run_op(18'h08000, 1'b0);
        chk("t1_ylat",  ylat, 9);
        chk("t1_rlat",  rlat, 9);
        chk("t1_y0",    cap_y, 18'h0);
        chk("t1_e0",    cap_e, 8'h0);
        run_op(18'h0, 1'b0);
        chk("t1_y1",    cap_y, 18'h0);
        run_op(18'h0, 1'b0);
        chk("t1_y2",    cap_y, 18'h0);
        run_op(18'h0, 1'b0);
        chk("t1_y3",    cap_y, 18'h07F00);
        chk("t1_e3",    cap_e, 8'h3D);
        chk("t1_ylat3", ylat, 9);

        // Test 2: update walk with +1 stub
        reset_dut();
        stub_mode = 2'd0;
        run_op(18'h01234, 1'b1);
        chk("t2_beats", nb, 7);
        chk("t2_ylat",  ylat, 9);
        chk("t2_rlat",  rlat, 16);
        ew = '{8'h00, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00};
        ex = '{18'h01234, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0};
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("t2a_idx%0d", k), bi[k], 40'(k));
            chk($sformatf("t2a_w%0d", k),   bw[k], ew[k]);
            chk($sformatf("t2a_xk%0d", k),  bx[k], ex[k]);
            chk($sformatf("t2a_fir%0d", k), bf[k], 18'h0);
        end
        run_op(18'h00567, 1'b1);
        chk("t2b_beats", nb, 7);
        chk("t2b_y",     cap_y, 18'h0002F);
        ew = '{8'h01, 8'h01, 8'h01, 8'h80, 8'h01, 8'h01, 8'h01};
        ex = '{18'h00567, 18'h01234, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0};
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("t2b_idx%0d", k), bi[k], 40'(k));
            chk($sformatf("t2b_w%0d", k),   bw[k], ew[k]);
            chk($sformatf("t2b_xk%0d", k),  bx[k], ex[k]);
            chk($sformatf("t2b_fir%0d", k), bf[k], 18'h0002F);
        end

        // Test 3: saturation of y and e
        reset_dut();
        stub_mode = 2'd1; stub_val = 8'h7F;
        run_op(18'h1FFFF, 1'b1);
        stub_mode = 2'd3;
        for (int k = 0; k < 6; k++) run_op(18'h1FFFF, 1'b0);
        chk("t3_ypos", cap_y, 18'h1FFFF);
        chk("t3_epos", cap_e, 8'h7F);
        for (int k = 0; k < 7; k++) run_op(18'h20000, 1'b0);
        chk("t3_yneg", cap_y, 18'h20000);
        chk("t3_eneg", cap_e, 8'h80);

        // Test 4: half-gain center tap, negative error
        reset_dut();
        stub_mode = 2'd2; stub_val = 8'h40;
        run_op(18'h0, 1'b1);
        stub_mode = 2'd3;
        run_op(18'h08000, 1'b0);
        chk("t4_y0", cap_y, 18'h0);
        for (int k = 0; k < 3; k++) run_op(18'h0, 1'b0);
        chk("t4_y", cap_y, 18'h04000);
        chk("t4_e", cap_e, 8'hF0);

        // Test 5: continuous valid
        reset_dut();
        i_adapt_en = 1'b0;
        stream(9, 6);
        chk("t5_bad_period", bad_int, 0);
        chk("t5_ready_wins", nacc, 7);
        chk("t5_y3", ys[3], 18'h000FE);
        chk("t5_y4", ys[4], 18'h001FC);
        chk("t5_y5", ys[5], 18'h002FA);
        reset_dut();
        i_adapt_en = 1'b1;
        stub_mode  = 2'd3;
        stream(16, 4);
        chk("t5a_bad_period", bad_int, 0);
        chk("t5a_ready_wins", nacc, 4);
        chk("t5a_y3", ys[3], 18'h000FE);

        // Test 6: abort in S_MAC then in S_UPD
        reset_dut();
        @(negedge clk);
        i_x = 18'h08000; i_valid = 1'b1; i_adapt_en = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        chk("t6m_ready", o_ready, 1);
        chk("t6m_yv",    o_y_valid, 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | o_y_valid;
        end
        chk("t6m_no_yv", seen, 0);

        stub_mode = 2'd0;
        @(negedge clk);
        i_x = 18'h00777; i_valid = 1'b1; i_adapt_en = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        found = 0;
        for (int n = 0; n < 30; n++) begin
            if (o_upd_valid && o_tap_idx == 3'd2) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("t6u_reach_beat2", found, 1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        chk("t6u_ready",   o_ready, 1);
        chk("t6u_upd",     o_upd_valid, 0);
        chk("t6u_tap_idx", o_tap_idx, 0);
        chk("t6u_yv",      o_y_valid, 0);
        stub_mode = 2'd3;
        run_op(18'h0, 1'b1);
        chk("t6r_beats", nb, 7);
        ew = '{8'h00, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00};
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("t6r_w%0d", k),  bw[k], ew[k]);
            chk($sformatf("t6r_xk%0d", k), bx[k], 18'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
